dm_lsu: RTL and testbench
=========================

DM_LSU -- requirements
Module: dm_lsu

Interface
REQ-001 The module SHALL have these ports, listed as name, direction, width, meaning:
- clk  in  1  CPU clock; all state updates on its rising edge.
- rstn  in  1  reset; asynchronous, active-low.
- req_valid  in  1  CPU access request valid.
- req_ready  out  1  LSU can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3: loads 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; stores 000 sb, 001 sh, 010 sw.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  CPU accepts the response.
- rsp_rdata  out  32  load result, extended per funct3; 0 for stores and errors.
- rsp_err  out  1  access rejected: misaligned-out-of-range, address over 0x1FF, or illegal funct3.
- DMWr  out  1  data-memory write strobe.
- addr  out  10  data-memory byte address.
- din  out  32  data-memory write data.
- DMType  out  3  data-memory access type: 000 word, 001 halfword, 010 halfword unsigned, 011 byte, 100 byte unsigned.
- dout  in  32  data-memory read data; combinational from addr and DMType.

Function
REQ-002 The FSM SHALL have four states: IDLE, ACC, SPLIT, RESP.
REQ-003 req_ready SHALL be 1 only in IDLE. A request is accepted on a cycle with req_valid && req_ready, and the LSU registers we, funct3, addr and wdata on that cycle.
REQ-004 Size SHALL be 1 for funct3 x00, 2 for x01, 4 for 010. Any other funct3, and any store with funct3[2]=1, is illegal.
REQ-005 An access is an error when it is illegal, when req_addr[31:10] != 0, or when req_addr + size - 1 > 0x1FF.
- On error: IDLE -> RESP with rsp_err=1 and rsp_rdata=0.
- No DMWr pulse is issued.
REQ-006 An aligned access (addr % size == 0) that is not an error SHALL go IDLE -> ACC -> RESP.
- In ACC: addr = req_addr[9:0]; DMType = type for funct3 (lw 000, lh 001, lhu 010, lb 011, lbu 100; sw 000, sh 001, sb 011); DMWr = we; din = wdata.
- For loads, rsp_rdata is captured from dout at the end of ACC.
REQ-007 A misaligned access that is not an error SHALL go IDLE -> SPLIT -> RESP.
- SPLIT lasts exactly size cycles, k = 0 .. size-1, driven by a 2-bit byte counter.
- In cycle k: addr = base + k; DMType = 011 for stores, 100 for loads; DMWr = we; din[7:0] = wdata[8k+7:8k] and din[31:8] = 0.
- For loads, byte k is assembled from dout[7:0]. After the final byte, lh sign-extends from bit 15 and lhu zero-extends.
REQ-008 rsp_valid SHALL be 1 exactly in RESP, and rsp_rdata and rsp_err SHALL be held stable there.
- RESP -> IDLE on rsp_ready=1.
- Back-to-back: the next request is accepted no earlier than the cycle after the response handshake.
REQ-009 Latency from the accept edge to rsp_valid SHALL be:
- error: 1 cycle;
- aligned: 2 cycles;
- misaligned halfword: 3 cycles;
- misaligned word: 5 cycles.
REQ-010 Outside ACC and SPLIT, DMWr SHALL be 0, addr 0, din 0, and DMType 000.
REQ-011 All outputs to the data memory SHALL be driven from registered state, with no combinational path from req_* to DMWr, addr or din.
REQ-012 rsp_rdata for stores SHALL be 0.

Reset
REQ-013 While rstn=0: state = IDLE, byte counter = 0, and captured registers = 0.
REQ-014 While rstn=0, outputs SHALL be: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, DMWr=0, addr=0, din=0, DMType=000.
REQ-015 Asserting rstn mid-ACC or mid-SPLIT SHALL abort immediately: DMWr drops asynchronously and no further byte writes occur. Bytes already written are not rolled back.

Verification
REQ-016 Aligned store/load: sw 0xDEADBEEF @0x010, then lw @0x010 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid 2 cycles after each accept, exactly one DMWr pulse with DMType=000.
REQ-017 Misaligned halfword: sh 0x00008001 @0x021 -> two DMWr pulses, addr 0x021 din 0x01 then addr 0x022 din 0x80. Then lh @0x021 -> 0xFFFF8001 and lhu @0x021 -> 0x00008001, each with rsp_valid 3 cycles after accept.
REQ-018 Errors, each with rsp_err=1, rsp_rdata=0, no DMWr, and rsp_valid 1 cycle after accept:
- lw @0x200;
- lw @0x1FE (misaligned and crossing 0x1FF);
- store with funct3=100.
REQ-019 Sign handling: sb 0x80 @0x005, then lb @0x005 -> 0xFFFFFF80 and lbu @0x005 -> 0x00000080.
REQ-020 Backpressure: hold rsp_ready=0 for 3 cycles after rsp_valid -> rsp_valid, rsp_rdata and rsp_err stay stable, req_ready=0, and a pending req_valid is not accepted until the cycle after the handshake.
REQ-021 Reset mid-split: misaligned sw 0x11223344 @0x041, with rstn=0 after the first byte write -> DMWr=0 immediately, mem[0x041]=0x44, mem[0x042..0x044] unchanged, and req_ready=1 after rstn returns to 1.

Source files
------------

// File: rtl/dm_lsu.sv
// rtl/dm_lsu.sv - load/store unit bridging CPU requests to a byte-addressed data memory
module dm_lsu (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        DMWr,
  output logic [9:0]  addr,
  output logic [31:0] din,
  output logic [2:0]  DMType,
  input  logic [31:0] dout
);

  typedef enum logic [1:0] {IDLE, ACC, SPLIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [9:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [2:0]  req_size;
  logic [10:0] req_last;
  logic        req_illegal;
  logic        req_bad;
  logic        req_misaligned;
  logic [2:0]  acc_type;
  logic [1:0]  split_last;

  // Classify the incoming request: access size, legality, range and alignment.
  always_comb begin
    req_size = 3'd1;
    case (req_funct3[1:0])
      2'b00:   req_size = 3'd1;
      2'b01:   req_size = 3'd2;
      2'b10:   req_size = 3'd4;
      default: req_size = 3'd1;
    endcase
    req_illegal    = (req_funct3[1:0] == 2'b11) || (req_funct3 == 3'b110) ||
                     (req_we && req_funct3[2]);
    req_last       = {1'b0, req_addr[9:0]} + {8'd0, req_size} - 11'd1;
    req_bad        = req_illegal || (|req_addr[31:10]) || (req_last > 11'h1FF);
    req_misaligned = ((req_size == 3'd2) && req_addr[0]) ||
                     ((req_size == 3'd4) && (|req_addr[1:0]));
  end

  // Memory access type for a whole aligned access, and final byte index of a split.
  always_comb begin
    acc_type = 3'b000;
    case (funct3_q)
      3'b010:  acc_type = 3'b000;
      3'b001:  acc_type = 3'b001;
      3'b101:  acc_type = 3'b010;
      3'b000:  acc_type = 3'b011;
      3'b100:  acc_type = 3'b100;
      default: acc_type = 3'b000;
    endcase
    split_last = funct3_q[1] ? 2'd3 : 2'd1;
  end

  // Next-state logic: request capture, byte sequencing and load data assembly.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_addr[9:0];
          wdata_d  = req_wdata;
          rdata_d  = 32'd0;
          cnt_d    = 2'd0;
          err_d    = req_bad;
          if (req_bad)             state_d = RESP;
          else if (req_misaligned) state_d = SPLIT;
          else                     state_d = ACC;
        end
      end
      ACC: begin
        if (!we_q) rdata_d = dout;
        state_d = RESP;
      end
      SPLIT: begin
        if (!we_q) begin
          rdata_d[{cnt_q, 3'b000} +: 8] = dout[7:0];
          if ((cnt_q == split_last) && (funct3_q == 3'b001)) rdata_d[31:16] = {16{dout[7]}};
        end
        if (cnt_q == split_last) begin
          cnt_d   = 2'd0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and capture registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= 2'd0;
      we_q     <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= 10'd0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Memory and handshake outputs decoded purely from registered state.
  always_comb begin
    DMWr      = 1'b0;
    addr      = 10'd0;
    din       = 32'd0;
    DMType    = 3'b000;
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    rsp_rdata = 32'd0;
    rsp_err   = 1'b0;
    case (state_q)
      ACC: begin
        DMWr   = we_q;
        addr   = addr_q;
        din    = wdata_q;
        DMType = acc_type;
      end
      SPLIT: begin
        DMWr   = we_q;
        addr   = addr_q + {8'd0, cnt_q};
        din    = {24'd0, wdata_q[{cnt_q, 3'b000} +: 8]};
        DMType = we_q ? 3'b011 : 3'b100;
      end
      RESP: begin
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dm_lsu.sv
// tb/tb_dm_lsu.sv - randomized and directed bench for dm_lsu against a byte-array model
module tb_dm_lsu;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        DMWr;
  logic [9:0]  addr;
  logic [31:0] din;
  logic [2:0]  DMType;
  logic [31:0] dout;

  dm_lsu dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .DMWr(DMWr), .addr(addr), .din(din), .DMType(DMType), .dout(dout)
  );

  always #5 clk = ~clk;

  // data memory seen by the DUT
  logic [7:0] mem [0:1023];
  logic [9:0] a1, a2, a3;
  assign a1 = addr + 10'd1;
  assign a2 = addr + 10'd2;
  assign a3 = addr + 10'd3;

  always_comb begin
    dout = 32'd0;
    case (DMType)
      3'b000:  dout = {mem[a3], mem[a2], mem[a1], mem[addr]};
      3'b001:  dout = {{16{mem[a1][7]}}, mem[a1], mem[addr]};
      3'b010:  dout = {16'd0, mem[a1], mem[addr]};
      3'b011:  dout = {{24{mem[addr][7]}}, mem[addr]};
      3'b100:  dout = {24'd0, mem[addr]};
      default: dout = 32'd0;
    endcase
  end

  always @(posedge clk) begin
    if (DMWr) begin
      mem[addr] <= din[7:0];
      if (DMType == 3'b000 || DMType == 3'b001 || DMType == 3'b010) mem[a1] <= din[15:8];
      if (DMType == 3'b000) begin
        mem[a2] <= din[23:16];
        mem[a3] <= din[31:24];
      end
    end
  end

  // reference model state
  logic [7:0]  ref_mem [0:1023];
  int          checks = 0;
  int          failures = 0;
  int          e_lat, e_beats;
  bit          e_err;
  bit [31:0]   e_rdata;
  bit [9:0]    e_addr [4];
  bit [31:0]   e_din  [4];
  bit [2:0]    e_type [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Expected bus beats, latency and response of one request, from the access rules.
  task automatic predict(input bit we, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] wd);
    int size;
    longint last;
    bit illegal;
    bit [31:0] v;
    size    = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    illegal = (f3[1:0] == 2'b11) || (f3 == 3'b110) || (we && f3[2]);
    last    = longint'(a) + size - 1;
    e_err   = illegal || (a > 32'h3FF) || (last > 64'h1FF);
    e_rdata = 32'd0;
    e_beats = 0;
    e_lat   = 1;
    if (!e_err) begin
      if (a % size == 0) begin
        e_beats = 1; e_lat = 2;
        e_addr[0] = a[9:0];
        e_din[0]  = wd;
        case (f3)
          3'b010: e_type[0] = 3'b000;
          3'b001: e_type[0] = 3'b001;
          3'b101: e_type[0] = 3'b010;
          3'b000: e_type[0] = 3'b011;
          default: e_type[0] = 3'b100;
        endcase
      end else begin
        e_beats = size; e_lat = size + 1;
        for (int k = 0; k < size; k++) begin
          e_addr[k] = a[9:0] + 10'(k);
          e_din[k]  = (wd >> (8 * k)) & 32'hFF;
          e_type[k] = we ? 3'b011 : 3'b100;
        end
      end
      if (we) begin
        for (int k = 0; k < size; k++) ref_mem[a + k] = 8'((wd >> (8 * k)) & 32'hFF);
      end else begin
        v = 32'd0;
        for (int k = 0; k < size; k++) v = v | (32'(ref_mem[a + k]) << (8 * k));
        if (!f3[2] && size < 4 && v[8 * size - 1]) v = v | (32'hFFFF_FFFF << (8 * size));
        e_rdata = v;
      end
    end
  endtask

  // Issue one request, compare every cycle up to and through the handshake.
  task automatic do_req(input bit we, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] wd,
                        input int hold, output logic [31:0] got_rdata, output logic got_err,
                        output int got_lat);
    int waited;
    logic [47:0] expv;
    predict(we, f3, a, wd);
    got_rdata = 32'hX; got_err = 1'bX; got_lat = 0;
    waited = 0;
    @(negedge clk);
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("req_ready_before_accept", {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    for (int c = 1; c <= e_lat + hold; c++) begin
      @(negedge clk);
      if (c == 1) req_valid = 1'b0;
      if (c < e_lat)
        expv = {1'b0, 1'b0, we, e_addr[c-1], e_din[c-1], e_type[c-1]};
      else
        expv = {1'b1, 1'b0, 1'b0, 10'd0, 32'd0, 3'd0};
      chk($sformatf("bus c=%0d a=%h f3=%0d we=%0d", c, a, f3, we),
          {16'd0, rsp_valid, req_ready, DMWr, addr, din, DMType}, {16'd0, expv});
      if (rsp_valid && got_lat == 0) begin
        got_lat = c; got_rdata = rsp_rdata; got_err = rsp_err;
      end
      if (c >= e_lat) begin
        chk("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, e_rdata});
        chk("rsp_err", {63'd0, rsp_err}, {63'd0, e_err});
        if (c < e_lat + hold) req_valid = 1'b1;
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    chk("idle_after_handshake", {62'd0, rsp_valid, req_ready}, 64'd1);
  endtask

  logic [31:0] r_rdata;
  logic        r_err;
  int          r_lat;
  logic [7:0]  saved [4];
  int          bad_bytes;
  bit [2:0]    f3_tab [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ref_mem[i] = 8'($urandom);
      mem[i] <= ref_mem[i];
    end
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {16'd0, rsp_valid, req_ready, DMWr, addr, din, DMType},
        {16'd0, 1'b0, 1'b1, 1'b0, 10'd0, 32'd0, 3'd0});
    chk("reset_rsp", {31'd0, rsp_rdata, rsp_err}, 64'd0);
    rstn = 1'b1;

    // aligned word store and load
    do_req(1'b1, 3'b010, 32'h010, 32'hDEADBEEF, 0, r_rdata, r_err, r_lat);
    chk("sw_lat", 64'(r_lat), 64'd2);
    do_req(1'b0, 3'b010, 32'h010, 32'h0, 0, r_rdata, r_err, r_lat);
    chk("lw_rdata", {32'd0, r_rdata}, 64'hDEADBEEF);
    chk("lw_lat", 64'(r_lat), 64'd2);

    // misaligned halfword
    do_req(1'b1, 3'b001, 32'h021, 32'h00008001, 0, r_rdata, r_err, r_lat);
    chk("sh_mis_lat", 64'(r_lat), 64'd3);
    do_req(1'b0, 3'b001, 32'h021, 32'h0, 0, r_rdata, r_err, r_lat);
    chk("lh_mis_rdata", {32'd0, r_rdata}, 64'hFFFF8001);
    chk("lh_mis_lat", 64'(r_lat), 64'd3);
    do_req(1'b0, 3'b101, 32'h021, 32'h0, 0, r_rdata, r_err, r_lat);
    chk("lhu_mis_rdata", {32'd0, r_rdata}, 64'h00008001);

    // errors
    do_req(1'b0, 3'b010, 32'h200, 32'h0, 0, r_rdata, r_err, r_lat);
    chk("err_range", {31'd0, r_err, r_rdata}, 64'h1_0000_0000);
    chk("err_range_lat", 64'(r_lat), 64'd1);
    do_req(1'b0, 3'b010, 32'h1FE, 32'h0, 0, r_rdata, r_err, r_lat);
    chk("err_cross", {31'd0, r_err, r_rdata}, 64'h1_0000_0000);
    do_req(1'b1, 3'b100, 32'h030, 32'h12345678, 0, r_rdata, r_err, r_lat);
    chk("err_store_f3", {31'd0, r_err, r_rdata}, 64'h1_0000_0000);
    chk("err_store_lat", 64'(r_lat), 64'd1);

    // byte sign handling
    do_req(1'b1, 3'b000, 32'h005, 32'h00000080, 0, r_rdata, r_err, r_lat);
    do_req(1'b0, 3'b000, 32'h005, 32'h0, 0, r_rdata, r_err, r_lat);
    chk("lb_rdata", {32'd0, r_rdata}, 64'hFFFFFF80);
    do_req(1'b0, 3'b100, 32'h005, 32'h0, 0, r_rdata, r_err, r_lat);
    chk("lbu_rdata", {32'd0, r_rdata}, 64'h00000080);

    // misaligned word
    do_req(1'b1, 3'b010, 32'h103, 32'hA1B2C3D4, 0, r_rdata, r_err, r_lat);
    chk("sw_mis_lat", 64'(r_lat), 64'd5);
    do_req(1'b0, 3'b010, 32'h103, 32'h0, 0, r_rdata, r_err, r_lat);
    chk("lw_mis_rdata", {32'd0, r_rdata}, 64'hA1B2C3D4);

    // backpressure with a pending request
    do_req(1'b0, 3'b010, 32'h010, 32'h0, 3, r_rdata, r_err, r_lat);
    chk("bp_rdata", {32'd0, r_rdata}, 64'hDEADBEEF);

    // reset in the middle of a split store
    for (int k = 0; k < 4; k++) saved[k] = ref_mem[32'h041 + k];
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h041; req_wdata = 32'h11223344;
    @(negedge clk);
    req_valid = 1'b0;
    chk("split_first_beat", {53'd0, DMWr, addr}, {53'd0, 1'b1, 10'h041});
    @(posedge clk);
    #2 rstn = 1'b0;
    #1 chk("dmwr_async_drop", {63'd0, DMWr}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {63'd0, req_ready}, 64'd1);
    ref_mem[32'h041] = 8'h44;
    chk("mem_041", {56'd0, mem[10'h041]}, 64'h44);
    chk("mem_042_044", {40'd0, mem[10'h044], mem[10'h043], mem[10'h042]},
        {40'd0, saved[3], saved[2], saved[1]});

    // randomized traffic
    for (int n = 0; n < 200; n++) begin
      int r;
      bit [31:0] a;
      bit [2:0] f3;
      bit we;
      r = $urandom_range(0, 9);
      if (r == 0)      a = $urandom;
      else if (r == 1) a = 32'h1F8 + $urandom_range(0, 7);
      else             a = $urandom_range(0, 32'h1FF);
      f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : f3_tab[$urandom_range(0, 4)];
      we = 1'($urandom_range(0, 1));
      do_req(we, f3, a, $urandom, $urandom_range(0, 2), r_rdata, r_err, r_lat);
    end

    bad_bytes = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad_bytes++;
    chk("final_mem_bad_bytes", 64'(bad_bytes), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
